mem_access_unit: RTL

- Multicycle-datapath memory stage directly downstream of the control FSM.
- Consumes the FSM's IorD, IRWrite, MemWrite and mem-read strobes.
- Runs one handshaked transaction at a time against a variable-latency word memory, then captures the result into the instruction register (IR) or the memory data register (MDR).
- Returns busy/done to the FSM and exports the opcode field to it.

---
 rtl/mem_access_unit_pkg.sv | 26 ++
 rtl/mem_access_unit_timeout.sv | 26 ++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared MIPS opcode, transaction-kind and state encodings.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        LOAD  = 2'b01,
        STORE = 2'b10
    } kind_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

endpackage

// File: rtl/mem_access_unit_timeout.sv
// mem_timeout_counter: counts REQ wait cycles; expired_o when the count reaches TIMEOUT-1.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : restart the count at zero
//   en_i       : advance the count by one
//   expired_o  : count has reached TIMEOUT-1
module mem_timeout_counter #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else if (en_i)    cnt_q <= cnt_q + TW'(1);
    end

    assign expired_o = cnt_q == TW'(TIMEOUT - 1);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle memory stage; one handshaked fetch/load/store at a time into IR or MDR.
//   clk, rst                   : clock, synchronous active-high reset
//   pc_i, alu_out_i, iord_i    : fetch address, data address, address select
//   b_reg_i                    : store data
//   ir_write_i, mem_write_i, mem_read_i : commands (priority in that order)
//   busy_o, done_o, err_o      : in flight, one-cycle completion, sticky error
//   instr_o, mdr_o, op_code_o  : IR, MDR, IR opcode field
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i, mem_ack_i : memory port
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pc_i,
    input  logic [N-1:0] alu_out_i,
    input  logic [N-1:0] b_reg_i,
    input  logic         iord_i,
    input  logic         ir_write_i,
    input  logic         mem_read_i,
    input  logic         mem_write_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [N-1:0] instr_o,
    output logic [N-1:0] mdr_o,
    output logic [5:0]   op_code_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [N-1:0] mem_addr_o,
    output logic [N-1:0] mem_wdata_o,
    input  logic [N-1:0] mem_rdata_i,
    input  logic         mem_ack_i
);

    state_e       state_q, state_d;
    kind_e        kind_q, kind_d;
    logic [N-1:0] addr_q, addr_d, wdata_q, wdata_d, instr_q, instr_d, mdr_q, mdr_d;
    logic         we_q, we_d, err_q, err_d;
    logic         cnt_clr, cnt_en, expired;
    logic         accept;
    logic [N-1:0] new_addr;

    mem_timeout_counter #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (expired)
    );

    assign accept   = state_q != REQ && (ir_write_i || mem_write_i || mem_read_i);
    assign new_addr = iord_i ? alu_out_i : pc_i;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        instr_d = instr_q;
        mdr_d   = mdr_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (accept) begin
            addr_d  = new_addr;
            wdata_d = b_reg_i;
            we_d    = !ir_write_i && mem_write_i;
            kind_d  = ir_write_i ? FETCH : (mem_write_i ? STORE : LOAD);
            cnt_clr = 1'b1;
            // misaligned word address completes immediately as an error, never touching memory
            err_d   = err_q || new_addr[1:0] != 2'b00;
            state_d = new_addr[1:0] != 2'b00 ? DONE : REQ;
        end else if (state_q == REQ) begin
            if (mem_ack_i) begin
                instr_d = kind_q == FETCH ? mem_rdata_i : instr_q;
                mdr_d   = kind_q == LOAD ? mem_rdata_i : mdr_q;
                state_d = DONE;
            end else if (expired) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                cnt_en  = 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kind_q  <= FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            instr_q <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = state_q == REQ;
    assign mem_req_o   = state_q == REQ;
    assign done_o      = state_q == DONE;
    assign err_o       = err_q;
    assign instr_o     = instr_q;
    assign mdr_o       = mdr_q;
    assign op_code_o   = instr_q[OP_HI:OP_LO];
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule
